// File: rtl/alu_rmw_seq.sv
// alu_rmw_seq: read-modify-write sequencer that runs a group-1 ALU operation on a memory
// destination over an 8-bit bus. Optional feature macro: ALU_RMW_LOCK_EN (adds the `lock` output).
`default_nettype none

module alu_rmw_seq #(
    parameter int ADDR_W = 20
) (
    input  logic              clock,
    input  logic              resetn,
    // Decoder handshake: `start` is a request taken only while idle (busy=0); the sequencer
    // then answers with exactly one single-cycle `done`, after which result/flags_o are valid.
    // Bus handshake: a strobe (mem_rd or mem_we) is held with a constant address/data until
    // the cycle in which mem_ready=1, which completes that access.
    input  logic              start,
    input  logic [3:0]        alumode_i,
    input  logic              isize_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       op2_i,
    input  logic [11:0]       flags_i,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_out,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [7:0]        mem_in,
    input  logic              mem_ready,
    output logic [3:0]        alu_mode,
    output logic              alu_isize,
    output logic [15:0]       alu_op1,
    output logic [15:0]       alu_op2,
    output logic [11:0]       alu_flags,
    input  logic [15:0]       alu_result,
    input  logic [11:0]       alu_flags_o,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic [11:0]       flags_o,
    output logic [2:0]        dbg_state
`ifdef ALU_RMW_LOCK_EN
    ,
    output logic              lock
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_EXEC  = 3'd3,
        S_WR_LO = 3'd4,
        S_WR_HI = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam logic [3:0]  MODE_CMP    = 4'd7;
    localparam logic [11:0] FLAGS_RESET = 12'h002;

    state_e              state_q, state_d;
    logic [3:0]          mode_q, mode_d;
    logic                isize_q, isize_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         op1_q, op1_d;
    logic [15:0]         op2_q, op2_d;
    logic [11:0]         fin_q, fin_d;
    logic [15:0]         result_q, result_d;
    logic [11:0]         flags_q, flags_d;

    logic [ADDR_W-1:0]   addr_hi;
    logic                is_cmp;

    // High byte address wraps naturally at the top of the address space.
    assign addr_hi = addr_q + ADDR_W'(1);
    assign is_cmp  = (mode_q == MODE_CMP);

`ifdef ALU_RMW_LOCK_EN
    logic lock_q, lock_d;
    logic last_access_done;

    // The final bus access is the last read for CMP and the last write otherwise.
    assign last_access_done =
        (state_q == S_RD_LO && mem_ready && !isize_q && is_cmp) ||
        (state_q == S_RD_HI && mem_ready && is_cmp) ||
        (state_q == S_WR_LO && mem_ready && !isize_q) ||
        (state_q == S_WR_HI && mem_ready);

    always_comb begin
        lock_d = lock_q;
        if (state_q == S_IDLE && start && !alumode_i[3]) begin
            lock_d = 1'b1;
        end else if (last_access_done) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        isize_d  = isize_q;
        addr_d   = addr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        fin_d    = fin_q;
        result_d = result_q;
        flags_d  = flags_q;
        mem_addr = '0;
        mem_out  = 8'h00;
        mem_rd   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = alumode_i;
                    isize_d = isize_i;
                    addr_d  = addr_i;
                    op2_d   = op2_i;
                    fin_d   = flags_i;
                    op1_d   = 16'h0000;
                    // Undefined opcodes finish at once and report the incoming flags.
                    if (alumode_i[3]) begin
                        result_d = 16'h0000;
                        flags_d  = flags_i;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RD_LO;
                    end
                end
            end
            S_RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    op1_d[7:0] = mem_in;
                    state_d    = isize_q ? S_RD_HI : S_EXEC;
                end
            end
            S_RD_HI: begin
                mem_rd   = 1'b1;
                mem_addr = addr_hi;
                if (mem_ready) begin
                    op1_d[15:8] = mem_in;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags_o;
                state_d  = is_cmp ? S_DONE : S_WR_LO;
            end
            S_WR_LO: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_out  = result_q[7:0];
                if (mem_ready) begin
                    state_d = isize_q ? S_WR_HI : S_DONE;
                end
            end
            S_WR_HI: begin
                mem_we   = 1'b1;
                mem_addr = addr_hi;
                mem_out  = result_q[15:8];
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mode_q   <= 4'h0;
            isize_q  <= 1'b0;
            addr_q   <= '0;
            op1_q    <= 16'h0000;
            op2_q    <= 16'h0000;
            fin_q    <= 12'h000;
            result_q <= 16'h0000;
            flags_q  <= FLAGS_RESET;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            isize_q  <= isize_d;
            addr_q   <= addr_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            fin_q    <= fin_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // The ALU sees only latched operands, so bus activity never disturbs its inputs.
    assign alu_mode  = mode_q;
    assign alu_isize = isize_q;
    assign alu_op1   = isize_q ? op1_q : {8'h00, op1_q[7:0]};
    assign alu_op2   = op2_q;
    assign alu_flags = fin_q;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign flags_o   = flags_q;
    assign dbg_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rmw_seq.sv
// tb_alu_rmw_seq: directed-vector bench for alu_rmw_seq with a byte memory model,
// a reference ALU, and queue-based scoreboards for completions, reads and writes.
module tb_alu_rmw_seq;

    localparam int ADDR_W = 20;

    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic              start     = 1'b0;
    logic [3:0]        alumode_i = 4'h0;
    logic              isize_i   = 1'b0;
    logic [ADDR_W-1:0] addr_i    = '0;
    logic [15:0]       op2_i     = 16'h0000;
    logic [11:0]       flags_i   = 12'h000;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_out;
    logic              mem_rd;
    logic              mem_we;
    logic [7:0]        mem_in    = 8'h00;
    logic              mem_ready;
    logic [3:0]        alu_mode;
    logic              alu_isize;
    logic [15:0]       alu_op1;
    logic [15:0]       alu_op2;
    logic [11:0]       alu_flags;
    logic [15:0]       alu_result;
    logic [11:0]       alu_flags_o;
    logic              busy;
    logic              done;
    logic [15:0]       result;
    logic [11:0]       flags_o;
    logic [2:0]        dbg_state;

    alu_rmw_seq #(.ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .alumode_i   (alumode_i),
        .isize_i     (isize_i),
        .addr_i      (addr_i),
        .op2_i       (op2_i),
        .flags_i     (flags_i),
        .mem_addr    (mem_addr),
        .mem_out     (mem_out),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_in      (mem_in),
        .mem_ready   (mem_ready),
        .alu_mode    (alu_mode),
        .alu_isize   (alu_isize),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_flags   (alu_flags),
        .alu_result  (alu_result),
        .alu_flags_o (alu_flags_o),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flags_o     (flags_o),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference ALU (x86 flag layout) ----------------
    function automatic logic [27:0] alu_model(input logic [3:0] m, input logic w,
                                              input logic [15:0] op1, input logic [15:0] op2,
                                              input logic [11:0] fi);
        logic [15:0] a, b, res, x;
        logic [16:0] r;
        logic        is_sub, is_logic, sa, sb, sr;
        logic [11:0] f;
        a = w ? op1 : {8'h00, op1[7:0]};
        b = w ? op2 : {8'h00, op2[7:0]};
        is_sub   = 1'b0;
        is_logic = 1'b0;
        case (m[2:0])
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: begin r = {1'b0, a | b}; is_logic = 1'b1; end
            3'd2: r = {1'b0, a} + {1'b0, b} + {16'h0000, fi[0]};
            3'd3: begin r = {1'b0, a} - {1'b0, b} - {16'h0000, fi[0]}; is_sub = 1'b1; end
            3'd4: begin r = {1'b0, a & b}; is_logic = 1'b1; end
            3'd6: begin r = {1'b0, a ^ b}; is_logic = 1'b1; end
            default: begin r = {1'b0, a} - {1'b0, b}; is_sub = 1'b1; end
        endcase
        res = w ? r[15:0] : {8'h00, r[7:0]};
        x   = a ^ b ^ r[15:0];
        sa  = w ? a[15] : a[7];
        sb  = w ? b[15] : b[7];
        sr  = w ? res[15] : res[7];
        f     = fi;
        f[1]  = 1'b1;
        f[0]  = is_logic ? 1'b0 : (w ? r[16] : r[8]);
        f[2]  = ~^res[7:0];
        f[4]  = is_logic ? 1'b0 : x[4];
        f[6]  = (res == 16'h0000);
        f[7]  = sr;
        f[11] = is_logic ? 1'b0 : (is_sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa)));
        return {f, res};
    endfunction

    assign {alu_flags_o, alu_result} = alu_model(alu_mode, alu_isize, alu_op1, alu_op2, alu_flags);

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int start_cyc = 0;
    logic [35:0] exp_q[$];      // {result, flags, latency}
    logic [27:0] exp_wr_q[$];   // {addr, data}
    logic [19:0] exp_rd_q[$];   // addr

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder ----------------
    logic [7:0] mem [logic [19:0]];
    int wait_cfg = 0;
    int wait_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [29:0] prev_bus   = '0;

    always @(posedge clock) begin
        if (!(mem_rd || mem_we)) wait_cnt <= wait_cfg;
        else if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
        else                    wait_cnt <= wait_cfg;
    end
    assign mem_ready = (wait_cnt == 0);

    always @(negedge clock) begin
        if (resetn) begin
            mem_in = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
            if (mem_rd || mem_we) chk("rd_we_exclusive", 32'(mem_rd & mem_we), 32'd0);
            if (prev_stall) chk("strobe_hold", 32'({mem_rd, mem_we, mem_addr, mem_out}), 32'(prev_bus));
            prev_stall = (mem_rd || mem_we) && !mem_ready;
            prev_bus   = {mem_rd, mem_we, mem_addr, mem_out};
            if (mem_rd && mem_ready) begin
                if (exp_rd_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFFFFFF);
                else chk("read_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
            end
            if (mem_we && mem_ready) begin
                if (exp_wr_q.size() == 0) chk("unexpected_write", 32'({mem_addr, mem_out}), 32'hFFFFFFFF);
                else chk("write_addr_data", 32'({mem_addr, mem_out}), 32'(exp_wr_q.pop_front()));
                mem[mem_addr] = mem_out;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- completion monitor ----------------
    always @(negedge clock) begin
        logic [35:0] e;
        if (resetn && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(result), 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("result",  32'(result),  32'(e[35:20]));
                chk("flags_o", 32'(flags_o), 32'(e[19:8]));
                chk("latency", 32'(cyc - start_cyc + 1), 32'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] m, input logic w, input logic [19:0] a,
                         input logic [15:0] b, input logic [11:0] f);
        @(negedge clock);
        alumode_i = m;
        isize_i   = w;
        addr_i    = a;
        op2_i     = b;
        flags_i   = f;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit seen_we;
        mem[20'h01000] = 8'h34; mem[20'h01001] = 8'h12;
        mem[20'h00200] = 8'h05;
        mem[20'hFFFFF] = 8'h00; mem[20'h00000] = 8'h10;
        mem[20'h03000] = 8'hFF;
        mem[20'h02000] = 8'hF0; mem[20'h02001] = 8'h0F;
        mem[20'h04000] = 8'hAA; mem[20'h04001] = 8'h55;
        mem[20'h05000] = 8'h10;

        #12;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_mem_rd",    32'(mem_rd),    32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_out",   32'(mem_out),   32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flags_o",   32'(flags_o),   32'h002);
        chk("rst_alu_op1",   32'(alu_op1),   32'd0);
        chk("rst_alu_op2",   32'(alu_op2),   32'd0);
        chk("rst_alu_flags", 32'(alu_flags), 32'd0);
        chk("rst_alu_mode",  32'({alu_mode, alu_isize}), 32'd0);
        chk("rst_state",     32'(dbg_state), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Word ADD: 0x1234 + 0x0001
        exp_rd_q.push_back(20'h01000); exp_rd_q.push_back(20'h01001);
        exp_wr_q.push_back({20'h01000, 8'h35}); exp_wr_q.push_back({20'h01001, 8'h12});
        exp_q.push_back({16'h1235, 12'h006, 8'd6});
        issue(4'd0, 1'b1, 20'h01000, 16'h0001, 12'h002);
        wait_done(30);

        // Byte CMP 0x05 vs 0x05: no write, Z set
        exp_rd_q.push_back(20'h00200);
        exp_q.push_back({16'h0000, 12'h046, 8'd3});
        issue(4'd7, 1'b0, 20'h00200, 16'h0005, 12'h002);
        wait_done(30);

        // Word SUB straddling the top of the address space
        exp_rd_q.push_back(20'hFFFFF); exp_rd_q.push_back(20'h00000);
        exp_wr_q.push_back({20'hFFFFF, 8'hFF}); exp_wr_q.push_back({20'h00000, 8'h0F});
        exp_q.push_back({16'h0FFF, 12'h016, 8'd6});
        issue(4'd5, 1'b1, 20'hFFFFF, 16'h0001, 12'h002);
        wait_done(30);

        // Byte ADC with carry in: 0xFF + 0x00 + 1
        exp_rd_q.push_back(20'h03000);
        exp_wr_q.push_back({20'h03000, 8'h00});
        exp_q.push_back({16'h0000, 12'h057, 8'd4});
        issue(4'd2, 1'b0, 20'h03000, 16'h0000, 12'h003);
        wait_done(30);

        // Word XOR with two wait cycles on each access
        wait_cfg = 2;
        exp_rd_q.push_back(20'h02000); exp_rd_q.push_back(20'h02001);
        exp_wr_q.push_back({20'h02000, 8'h0F}); exp_wr_q.push_back({20'h02001, 8'h0F});
        exp_q.push_back({16'h0F0F, 12'h206, 8'd14});
        issue(4'd6, 1'b1, 20'h02000, 16'h00FF, 12'h203);
        wait_done(60);
        wait_cfg = 0;

        // Word AND with a stray start mid-operation
        exp_rd_q.push_back(20'h04000); exp_rd_q.push_back(20'h04001);
        exp_wr_q.push_back({20'h04000, 8'hA0}); exp_wr_q.push_back({20'h04001, 8'h05});
        exp_q.push_back({16'h05A0, 12'h006, 8'd6});
        issue(4'd4, 1'b1, 20'h04000, 16'h0FF0, 12'h002);
        @(negedge clock);
        alumode_i = 4'd0; isize_i = 1'b0; addr_i = 20'h0ABCD; op2_i = 16'hFFFF; flags_i = 12'hFFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(30);

        // Undefined opcode: immediate completion with incoming flags
        exp_q.push_back({16'h0000, 12'h8D5, 8'd1});
        issue(4'd9, 1'b1, 20'h01000, 16'h1111, 12'h8D5);
        wait_done(10);

        // Reset while a write is stalled
        wait_cfg = 3;
        exp_rd_q.push_back(20'h05000);
        issue(4'd0, 1'b0, 20'h05000, 16'h0001, 12'h002);
        seen_we = 1'b0;
        for (int i = 0; i < 40 && !seen_we; i++) begin
            @(negedge clock);
            if (mem_we) seen_we = 1'b1;
        end
        chk("reached_wr_lo", 32'(seen_we), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_mem_we",  32'(mem_we),    32'd0);
        chk("midrst_busy",    32'(busy),      32'd0);
        chk("midrst_state",   32'(dbg_state), 32'd0);
        chk("midrst_result",  32'(result),    32'd0);
        chk("midrst_flags_o", 32'(flags_o),   32'h002);
        chk("midrst_mem_kept", 32'(mem[20'h05000]), 32'h10);
        wait_cfg = 0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Fresh byte OR after reset
        exp_rd_q.push_back(20'h05000);
        exp_wr_q.push_back({20'h05000, 8'h11});
        exp_q.push_back({16'h0011, 12'h006, 8'd4});
        issue(4'd1, 1'b0, 20'h05000, 16'h0001, 12'h002);
        wait_done(30);
        @(negedge clock);

        chk("exp_q_drained",    32'(exp_q.size()),    32'd0);
        chk("exp_rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
        chk("exp_wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("final_busy",       32'(busy),            32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
